// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates the shared burst memory port between icache and dcache line requests.
// Round-robin on ties; the winner's request is latched and drives the port until mem_resp.
module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    // state   | meaning
    // IDLE    | no grant; pick a requester, round-robin on ties
    // GRANT_I | icache owns the port until mem_resp
    // GRANT_D | dcache owns the port until mem_resp
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  lat_read, lat_read_nxt;
    logic                  lat_write, lat_write_nxt;
    logic [ADDR_WIDTH-1:0] lat_address, lat_address_nxt;
    logic [LINE_WIDTH-1:0] lat_wdata, lat_wdata_nxt;

    logic i_req;
    logic d_req;
    logic granted;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        lat_read_nxt    = lat_read;
        lat_write_nxt   = lat_write;
        lat_address_nxt = lat_address;
        lat_wdata_nxt   = lat_wdata;
        case (state)
            IDLE: begin
                // icache wins when alone or when the dcache was served last
                if (i_req && (!d_req || last_grant)) begin
                    state_nxt       = GRANT_I;
                    last_grant_nxt  = 1'b0;
                    lat_read_nxt    = 1'b1;
                    lat_write_nxt   = 1'b0;
                    lat_address_nxt = i_address;
                    lat_wdata_nxt   = '0;
                end else if (d_req) begin
                    state_nxt       = GRANT_D;
                    last_grant_nxt  = 1'b1;
                    lat_read_nxt    = d_read & ~d_write;
                    lat_write_nxt   = d_write;
                    lat_address_nxt = d_address;
                    lat_wdata_nxt   = d_wdata;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            lat_read    <= 1'b0;
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            lat_read    <= lat_read_nxt;
            lat_write   <= lat_write_nxt;
            lat_address <= lat_address_nxt;
            lat_wdata   <= lat_wdata_nxt;
        end
    end

    assign granted     = (state != IDLE);
    assign mem_read    = granted & lat_read;
    assign mem_write   = granted & lat_write;
    assign mem_address = granted ? lat_address : '0;
    assign mem_wdata   = (state == GRANT_D) ? lat_wdata : '0;

    // Responses are steered only to the owner; a stray mem_resp in IDLE goes nowhere
    assign i_resp  = (state == GRANT_I) & mem_resp;
    assign d_resp  = (state == GRANT_D) & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

    a_d_read_write_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter: directed scenarios followed by
// randomized traffic, all outputs compared each cycle against a transaction-level model.
module tb_cacheline_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cacheline_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the port (0 none, 1 icache, 2 dcache) and the captured request
    int            m_owner;
    bit            m_last_d;
    bit            m_rd;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            seen_i_resp;
    bit            seen_d_resp;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic compare_all();
        logic e_ir;
        logic e_dr;
        e_ir = (m_owner == 1) && mem_resp;
        e_dr = (m_owner == 2) && mem_resp;
        seen_i_resp = e_ir;
        seen_d_resp = e_dr;
        check("mem_read", mem_read, (m_owner != 0) && m_rd);
        check("mem_write", mem_write, (m_owner != 0) && m_wr);
        check("mem_address", mem_address, (m_owner != 0) ? m_addr : '0);
        check("mem_wdata", mem_wdata, (m_owner == 2) ? m_wdata : '0);
        check("i_resp", i_resp, e_ir);
        check("d_resp", d_resp, e_dr);
        check("i_rdata", i_rdata, e_ir ? mem_rdata : '0);
        check("d_rdata", d_rdata, e_dr ? mem_rdata : '0);
    endtask

    task automatic model_update();
        bit want_i;
        bit want_d;
        want_i = i_read;
        want_d = d_read || d_write;
        if (rst) begin
            m_owner = 0; m_last_d = 1; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        end else if (m_owner == 0) begin
            if (want_i && (!want_d || m_last_d)) begin
                m_owner = 1; m_last_d = 0; m_rd = 1; m_wr = 0; m_addr = i_address; m_wdata = '0;
            end else if (want_d) begin
                m_owner = 2; m_last_d = 1; m_wr = d_write; m_rd = d_read && !d_write;
                m_addr = d_address; m_wdata = d_wdata;
            end
        end else if (mem_resp) begin
            m_owner = 0;
        end
    endtask

    // Inputs are set just after a falling edge; outputs checked 1ns later, model advanced at the rising edge
    task automatic cycle();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0;
        d_wdata = '0; mem_rdata = '0; mem_resp = 0;
        m_owner = 0; m_last_d = 1; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        @(negedge clk);
        cycle();
        #1 check("reset_mem_read", mem_read, 0);
        check("reset_mem_address", mem_address, 0);
        cycle();
        rst = 0;

        // icache read of 0x60
        i_read = 1; i_address = 32'h60;
        cycle();
        #1 check("i_first_mem_read", mem_read, 1);
        check("i_first_address", mem_address, 32'h60);
        cycle();
        mem_resp = 1; mem_rdata = {32{8'hA5}};
        #1 check("i_first_rdata", i_rdata, {32{8'hA5}});
        check("i_first_d_resp", d_resp, 0);
        cycle();
        i_read = 0; mem_resp = 0;
        cycle();

        // dcache writeback of 0x1000
        d_write = 1; d_address = 32'h1000; d_wdata = {8{32'h12345678}};
        cycle();
        #1 check("d_wb_mem_write", mem_write, 1);
        check("d_wb_wdata", mem_wdata, {8{32'h12345678}});
        mem_resp = 1;
        cycle();
        d_write = 0; mem_resp = 0;
        cycle();

        // Tie: dcache was served last, so icache first; then dcache, with a mid-grant address change
        i_read = 1; i_address = 32'h40; d_read = 1; d_address = 32'h80;
        cycle();
        #1 check("tie1_address", mem_address, 32'h40);
        mem_resp = 1;
        cycle();
        i_read = 0; mem_resp = 0;
        cycle();
        cycle();
        #1 check("tie1_second_address", mem_address, 32'h80);
        d_address = 32'hC0; i_read = 1; i_address = 32'h40;
        cycle();
        #1 check("latched_address", mem_address, 32'h80);
        mem_resp = 1;
        cycle();
        d_read = 0; mem_resp = 0;
        cycle();
        cycle();
        #1 check("i_after_d_address", mem_address, 32'h40);
        mem_resp = 1;
        cycle();
        i_read = 0; mem_resp = 0;
        cycle();
        // Second tie: icache was last, so dcache wins
        i_read = 1; d_read = 1; i_address = 32'h40; d_address = 32'h80;
        cycle();
        #1 check("tie2_d_first", mem_address, 32'h80);
        mem_resp = 1;
        cycle();
        d_read = 0; mem_resp = 0;
        cycle();
        cycle();
        mem_resp = 1;
        cycle();
        i_read = 0; mem_resp = 0;
        cycle();

        // Reset during an icache grant, then a stray response
        i_read = 1; i_address = 32'h200;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0; i_read = 0; mem_resp = 1;
        #1 check("post_reset_i_resp", i_resp, 0);
        check("post_reset_mem_read", mem_read, 0);
        cycle();
        mem_resp = 0; i_read = 1; i_address = 32'h300; d_read = 1; d_address = 32'h400;
        cycle();
        #1 check("post_reset_tie_i", mem_address, 32'h300);
        mem_resp = 1;
        cycle();
        i_read = 0; mem_resp = 0;
        cycle();
        cycle();
        mem_resp = 1;
        cycle();
        d_read = 0; mem_resp = 0;
        cycle();

        // mem_resp in IDLE with nothing pending
        mem_resp = 1;
        #1 check("idle_resp_i", i_resp, 0);
        check("idle_resp_d", d_resp, 0);
        cycle();
        mem_resp = 0;
        cycle();
        #1 check("idle_stays_idle", mem_read | mem_write, 0);

        // Randomized traffic obeying the requester contract
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1; i_address = $urandom;
            end else if (i_read && $urandom_range(0, 7) == 0) begin
                i_address = $urandom;
            end
            if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
                d_address = $urandom; d_wdata = rand_line();
            end else if ((d_read || d_write) && $urandom_range(0, 7) == 0) begin
                d_address = $urandom; d_wdata = rand_line();
            end
            mem_resp = ($urandom_range(0, 2) == 0);
            mem_rdata = rand_line();
            cycle();
            if (seen_i_resp) i_read = 0;
            if (seen_d_resp) begin d_read = 0; d_write = 0; end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
Shares the single burst physical-memory port between the instruction cache and the data cache miss/writeback paths in mp4. Each cache presents a cacheline-wide request. The arbiter grants one requester at a time, drives the shared port from registered copies of the request, and routes mem_resp/mem_rdata back only to the granted cache. It sits between icache/dcache and the mp4 top-level mem_* ports.

Parameters:
ADDR_WIDTH, 32, byte address width of all request and memory addresses.
LINE_WIDTH, 256, cacheline data width in bits.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
i_read  input  1  icache line-read request, held until i_resp
i_address  input  ADDR_WIDTH  icache line address
i_rdata  output  LINE_WIDTH  line data returned to icache
i_resp  output  1  one-cycle completion pulse to icache
d_read  input  1  dcache line-read request, held until d_resp
d_write  input  1  dcache line-writeback request, held until d_resp
d_address  input  ADDR_WIDTH  dcache line address
d_wdata  input  LINE_WIDTH  dcache writeback data
d_rdata  output  LINE_WIDTH  line data returned to dcache
d_resp  output  1  one-cycle completion pulse to dcache
mem_read  output  1  shared port read
mem_write  output  1  shared port write
mem_address  output  ADDR_WIDTH  shared port address
mem_wdata  output  LINE_WIDTH  shared port write data
mem_rdata  input  LINE_WIDTH  shared port read data
mem_resp  input  1  shared port completion

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- States: IDLE, GRANT_I, GRANT_D.
- Additional registers: last_grant (0 = icache, 1 = dcache), plus latched op/address/wdata.
- Reset: state=IDLE, last_grant=1, latches cleared. All outputs are 0 (mem_read, mem_write, mem_address, mem_wdata, i_resp, d_resp, i_rdata, d_rdata).
- rst asserted mid-transaction:
  - Abandon the transaction and return to IDLE next edge.
  - Any mem_resp arriving while in IDLE or after reset is ignored and is never forwarded.
- IDLE, request selection:
  - No request: stay in IDLE.
  - Only icache requesting: go to GRANT_I.
  - Only dcache requesting (d_read|d_write): go to GRANT_D.
  - Both requesting: grant the requester that is not last_grant (round-robin). With last_grant=1 after reset, the icache wins the first tie.
- Entering a grant: on the transition edge, latch op/address/wdata from the winner and update last_grant.
- d_read and d_write both high: treat as a write (write wins). Flag it with a simulation-only assertion.
- GRANT_x outputs:
  - mem_read/mem_write/mem_address/mem_wdata are driven from the latches, held constant for the whole grant.
  - In GRANT_I, mem_write=0 and mem_wdata=0.
- Latency: a request seen in IDLE at cycle N gives mem_* asserted in cycle N+1. Minimum turnaround is one IDLE cycle between grants.
- Response routing (combinational):
  - In GRANT_I, i_resp=mem_resp and i_rdata=mem_rdata.
  - In GRANT_D, d_resp=mem_resp and d_rdata=mem_rdata.
  - The non-granted resp is always 0.
  - Both rdata outputs are 0 unless the corresponding resp is high.
- On mem_resp=1 in GRANT_x:
  - Return to IDLE next edge.
  - mem_read/mem_write deassert in the following cycle.
- Requester contract: a cache drops its request in the cycle after its resp. Request changes during a grant are ignored, because the latched values are used.
- Starvation bound: a continuously pending requester waits at most one competing transaction.
- Widths: no arithmetic. Address and data pass through unmodified with no alignment or masking.

Test Plan:
- Reset, then i_read=1 with i_address=0x00000060 → mem_read=1, mem_address=0x60 in the next cycle. Drive mem_resp with mem_rdata=256'hA5…A5 → i_resp=1, i_rdata=A5…A5 in the same cycle, d_resp=0; mem_read drops the next cycle.
- d_write=1 with d_address=0x1000 and d_wdata=256'h1234…, while i_read is idle → mem_write=1, mem_address=0x1000, mem_wdata matches. mem_resp produces d_resp only.
- i_read and d_read raised in the same cycle after reset → icache is served first (address 0x40). After its resp and one IDLE cycle, dcache is served (address 0x80). Repeating the tie gives strict alternation, with the dcache first on the next tie.
- During GRANT_D, change d_address from 0x80 to 0xC0 and raise i_read → mem_address stays 0x80 until mem_resp; the icache is granted next.
- Assert rst mid-GRANT_I, then pulse mem_resp one cycle after reset deasserts → all outputs are 0 and i_resp stays 0. A fresh d_read is granted with last_grant behaviour as after reset.
- mem_resp pulsed while in IDLE with no requests → i_resp=d_resp=0 and the state stays IDLE.
